// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU ops, states, mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_BNE      = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;
    localparam logic [2:0] ALU_XOR   = 3'd6;
    localparam logic [2:0] ALU_LUI   = 3'd7;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] M2R_ALUOUT   = 2'd0;
    localparam logic [1:0] M2R_MDR      = 2'd1;
    localparam logic [1:0] M2R_PC       = 2'd2;
    localparam logic [1:0] RDST_RT      = 2'd0;
    localparam logic [1:0] RDST_RD      = 2'd1;
    localparam logic [1:0] RDST_RA      = 2'd2;
    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_SLTI: return ALU_SLT;
            OP_XORI: return ALU_XOR;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory state; flags timeout combinationally.
// Latency: timeout asserts in the MEM_TIMEOUT-th consecutive stalled cycle. No backpressure.
// Restart clears the count on every state change so each wait state starts from zero.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic restart,
    input  logic ready,
    output logic timeout
);

    logic [7:0] cnt;

    assign timeout = active && !ready && (cnt == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (restart || !active) begin
            cnt <= 8'd0;
        end else if (!ready) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: per-state datapath strobes, memory wait handshake, timeout trap.
// Latency: 3-5 cycles per instruction plus memory wait states. Mem_Ready stalls FETCH/MEM_RD/MEM_WR.
// Strobes are registered from the next state; IR_Write/PC_Write in FETCH and Illegal_Op follow inputs.
module multi_cycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             Run,
    input  logic [5:0]       Inst_31_26,
    input  logic             Mem_Ready,
    output logic             PC_Write,
    output logic             PC_Write_Cond,
    output logic [1:0]       PC_Source,
    output logic             IorD,
    output logic             IR_Write,
    output logic             Mem_Read,
    output logic             Mem_Write,
    output logic [1:0]       Mem_to_Reg,
    output logic [1:0]       Reg_Dst,
    output logic             Reg_Write,
    output logic             ALU_Src_A,
    output logic [1:0]       ALU_Src_B,
    output logic [2:0]       ALU_Op,
    output logic             Illegal_Op,
    output logic             Fault,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] Instr_Count
);

    state_t           state, nxt;
    ctrl_t            ctl, ctl_n;
    logic [5:0]       op_reg, op_cur;
    logic             retire, wait_st, timeout, illegal, fetch_done;
    logic [CNT_W-1:0] icnt;
    logic             fault_q;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (Clk),
        .rst_n   (Reset_N),
        .active  (wait_st),
        .restart (nxt != state),
        .ready   (Mem_Ready),
        .timeout (timeout)
    );

    always_comb begin
        op_cur  = (state == S_DECODE) ? Inst_31_26 : op_reg;
        wait_st = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
        illegal = 1'b0;
        retire  = 1'b0;
        nxt     = state;
        case (state)
            S_IDLE:     if (Run) nxt = S_FETCH;
            S_FETCH:    if (Mem_Ready) nxt = S_DECODE; else if (timeout) nxt = S_TRAP;
            S_DECODE: begin
                case (Inst_31_26)
                    OP_RTYPE:                 nxt = S_R_EXEC;
                    OP_LW, OP_SW:             nxt = S_MEM_ADDR;
                    OP_ADDI, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI:  nxt = S_I_EXEC;
                    OP_BNE:                   nxt = S_BNE;
                    OP_J:                     nxt = S_JUMP;
                    OP_JAL:                   nxt = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        nxt     = Run ? S_FETCH : S_IDLE;
                    end
                endcase
            end
            S_MEM_ADDR: nxt = (op_reg == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (Mem_Ready) nxt = S_MEM_WB; else if (timeout) nxt = S_TRAP;
            S_MEM_WR:   if (Mem_Ready) retire = 1'b1; else if (timeout) nxt = S_TRAP;
            S_R_EXEC:   nxt = S_R_WB;
            S_I_EXEC:   nxt = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BNE, S_JUMP, S_JAL: retire = 1'b1;
            S_TRAP:     nxt = S_TRAP;
            default:    nxt = S_IDLE;
        endcase
        if (retire) nxt = Run ? S_FETCH : S_IDLE;
    end

    // Decode strobes for the state being entered so they are registered on arrival.
    always_comb begin
        ctl_n = '0;
        case (nxt)
            S_FETCH: begin
                ctl_n.mem_read  = 1'b1;
                ctl_n.alu_src_b = SRCB_FOUR;
            end
            S_DECODE:   ctl_n.alu_src_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
                ctl_n.alu_src_a = 1'b1;
                ctl_n.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctl_n.mem_read = 1'b1;
                ctl_n.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctl_n.reg_write  = 1'b1;
                ctl_n.mem_to_reg = M2R_MDR;
            end
            S_MEM_WR: begin
                ctl_n.mem_write = 1'b1;
                ctl_n.iord      = 1'b1;
            end
            S_R_EXEC: begin
                ctl_n.alu_src_a = 1'b1;
                ctl_n.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctl_n.reg_write = 1'b1;
                ctl_n.reg_dst   = RDST_RD;
            end
            S_I_EXEC: begin
                ctl_n.alu_src_a = 1'b1;
                ctl_n.alu_src_b = SRCB_IMM;
                ctl_n.alu_op    = imm_alu_op(op_cur);
            end
            S_I_WB:     ctl_n.reg_write = 1'b1;
            S_BNE: begin
                ctl_n.alu_src_a     = 1'b1;
                ctl_n.alu_op        = ALU_SUB;
                ctl_n.pc_write_cond = 1'b1;
                ctl_n.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctl_n.pc_write  = 1'b1;
                ctl_n.pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                ctl_n.pc_write   = 1'b1;
                ctl_n.pc_source  = PCSRC_JUMP;
                ctl_n.reg_write  = 1'b1;
                ctl_n.reg_dst    = RDST_RA;
                ctl_n.mem_to_reg = M2R_PC;
            end
            default: ctl_n = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state   <= S_IDLE;
            ctl     <= '0;
            op_reg  <= 6'd0;
            fault_q <= 1'b0;
            icnt    <= '0;
        end else begin
            state <= nxt;
            ctl   <= ctl_n;
            if (state == S_DECODE) op_reg <= Inst_31_26;
            if (nxt == S_TRAP) fault_q <= 1'b1;
            if (retire) icnt <= icnt + CNT_W'(1);
        end
    end

    assign fetch_done    = (state == S_FETCH) && Mem_Ready;
    assign PC_Write      = ctl.pc_write | fetch_done;
    assign IR_Write      = fetch_done;
    assign PC_Write_Cond = ctl.pc_write_cond;
    assign PC_Source     = ctl.pc_source;
    assign IorD          = ctl.iord;
    assign Mem_Read      = ctl.mem_read;
    assign Mem_Write     = ctl.mem_write;
    assign Mem_to_Reg    = ctl.mem_to_reg;
    assign Reg_Dst       = ctl.reg_dst;
    assign Reg_Write     = ctl.reg_write;
    assign ALU_Src_A     = ctl.alu_src_a;
    assign ALU_Src_B     = ctl.alu_src_b;
    assign ALU_Op        = ctl.alu_op;
    assign Illegal_Op    = illegal;
    assign Fault         = fault_q;
    assign State         = state;
    assign Instr_Count   = icnt;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed scoreboard bench for multi_cycle_control: per-cycle expected outputs queued and compared.
module tb_multi_cycle_control;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        Run = 1'b0;
    logic [5:0]  Inst_31_26 = 6'd0;
    logic        Mem_Ready = 1'b0;
    logic        PC_Write, PC_Write_Cond, IorD, IR_Write, Mem_Read, Mem_Write;
    logic        Reg_Write, ALU_Src_A, Illegal_Op, Fault;
    logic [1:0]  PC_Source, Mem_to_Reg, Reg_Dst, ALU_Src_B;
    logic [2:0]  ALU_Op;
    logic [3:0]  State;
    logic [31:0] Instr_Count;

    multi_cycle_control #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .Run(Run), .Inst_31_26(Inst_31_26),
        .Mem_Ready(Mem_Ready), .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond),
        .PC_Source(PC_Source), .IorD(IorD), .IR_Write(IR_Write), .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write), .Mem_to_Reg(Mem_to_Reg), .Reg_Dst(Reg_Dst),
        .Reg_Write(Reg_Write), .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B),
        .ALU_Op(ALU_Op), .Illegal_Op(Illegal_Op), .Fault(Fault), .State(State),
        .Instr_Count(Instr_Count)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw, pcwc;
        logic [1:0]  pcs;
        logic        iord, irw, mr, mw;
        logic [1:0]  m2r, rdst;
        logic        rw, sa;
        logic [1:0]  srcb;
        logic [2:0]  aop;
        logic        ill, fault;
        logic [31:0] cnt;
    } obs_t;

    obs_t obs;
    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic        exp_fault = 1'b0;

    localparam logic [3:0] IDLE = 0, FETCH = 1, DECODE = 2, MADDR = 3, MRD = 4, MWB = 5,
                           MWR = 6, REX = 7, RWB = 8, IEX = 9, IWB = 10, BNE = 11,
                           JMP = 12, JAL = 13, TRAP = 14;

    always_comb begin
        obs = '{st: State, pcw: PC_Write, pcwc: PC_Write_Cond, pcs: PC_Source, iord: IorD,
                irw: IR_Write, mr: Mem_Read, mw: Mem_Write, m2r: Mem_to_Reg, rdst: Reg_Dst,
                rw: Reg_Write, sa: ALU_Src_A, srcb: ALU_Src_B, aop: ALU_Op, ill: Illegal_Op,
                fault: Fault, cnt: Instr_Count};
    end

    // Expected outputs per state, written from the control table of the block.
    function automatic obs_t ex(input logic [3:0] st, input logic rdy, input logic ill,
                                input logic [2:0] iop);
        obs_t e;
        e = '0;
        e.st    = st;
        e.fault = exp_fault;
        e.cnt   = exp_cnt;
        case (st)
            FETCH:  begin e.mr = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            DECODE: begin e.srcb = 2'b11; e.ill = ill; end
            MADDR:  begin e.sa = 1; e.srcb = 2'b10; end
            MRD:    begin e.mr = 1; e.iord = 1; end
            MWB:    begin e.rw = 1; e.m2r = 2'b01; end
            MWR:    begin e.mw = 1; e.iord = 1; end
            REX:    begin e.sa = 1; e.aop = 3'b010; end
            RWB:    begin e.rw = 1; e.rdst = 2'b01; end
            IEX:    begin e.sa = 1; e.srcb = 2'b10; e.aop = iop; end
            IWB:    begin e.rw = 1; end
            BNE:    begin e.sa = 1; e.aop = 3'b001; e.pcwc = 1; e.pcs = 2'b01; end
            JMP:    begin e.pcw = 1; e.pcs = 2'b10; end
            JAL:    begin e.pcw = 1; e.pcs = 2'b10; e.rw = 1; e.rdst = 2'b10; e.m2r = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic compare(input string tag);
        obs_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (obs.st === e.st) else begin
                errors++;
                $error("FAIL %s state obs=%0d exp=%0d", tag, obs.st, e.st);
            end
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s outputs obs=%h exp=%h", tag, obs, e);
            end
        end
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic run,
                        input logic rdy, input logic [5:0] op, input logic ill,
                        input logic [2:0] iop);
        Run = run;
        Mem_Ready = rdy;
        Inst_31_26 = op;
        #1;
        sb.push_back(ex(st, rdy, ill, iop));
        compare(tag);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        sb.push_back(ex(IDLE, 0, 0, 0));
        compare("reset");
        @(posedge Clk); #1;
        Reset_N = 1'b1;

        // R-type, zero wait states: 4 cycles
        step("r_idle",   IDLE,   1, 1, 6'd0, 0, 0);
        step("r_fetch",  FETCH,  1, 1, 6'd0, 0, 0);
        step("r_decode", DECODE, 1, 1, 6'd0, 0, 0);
        step("r_exec",   REX,    1, 1, 6'd0, 0, 0);
        step("r_wb",     RWB,    1, 1, 6'd0, 0, 0);
        exp_cnt++;

        // lw with 3 wait states in MEM_RD: 8 cycles
        step("lw_fetch", FETCH,  1, 1, 6'd35, 0, 0);
        step("lw_dec",   DECODE, 1, 1, 6'd35, 0, 0);
        step("lw_addr",  MADDR,  1, 1, 6'd35, 0, 0);
        for (int i = 0; i < 3; i++) step("lw_wait", MRD, 1, 0, 6'd35, 0, 0);
        step("lw_rd",    MRD,    1, 1, 6'd35, 0, 0);
        step("lw_wb",    MWB,    1, 1, 6'd35, 0, 0);
        exp_cnt++;

        // ori then jal
        step("ori_fetch", FETCH,  1, 1, 6'd13, 0, 0);
        step("ori_dec",   DECODE, 1, 1, 6'd13, 0, 0);
        step("ori_exec",  IEX,    1, 1, 6'd13, 0, 3'b100);
        step("ori_wb",    IWB,    1, 1, 6'd13, 0, 0);
        exp_cnt++;
        step("jal_fetch", FETCH,  1, 1, 6'd3, 0, 0);
        step("jal_dec",   DECODE, 1, 1, 6'd3, 0, 0);
        step("jal",       JAL,    1, 1, 6'd3, 0, 0);
        exp_cnt++;

        // Illegal opcode: pulse in DECODE, back to FETCH, not counted
        step("ill_fetch", FETCH,  1, 1, 6'd63, 0, 0);
        step("ill_dec",   DECODE, 1, 1, 6'd63, 1, 0);

        // sw, bne, then j with Run dropped mid-instruction
        step("sw_fetch",  FETCH,  1, 1, 6'd43, 0, 0);
        step("sw_dec",    DECODE, 1, 1, 6'd43, 0, 0);
        step("sw_addr",   MADDR,  1, 1, 6'd43, 0, 0);
        step("sw_wr",     MWR,    1, 1, 6'd43, 0, 0);
        exp_cnt++;
        step("bne_fetch", FETCH,  1, 1, 6'd5, 0, 0);
        step("bne_dec",   DECODE, 1, 1, 6'd5, 0, 0);
        step("bne",       BNE,    1, 1, 6'd5, 0, 0);
        exp_cnt++;
        step("j_fetch",   FETCH,  1, 1, 6'd2, 0, 0);
        step("j_dec",     DECODE, 0, 1, 6'd2, 0, 0);
        step("j",         JMP,    0, 1, 6'd2, 0, 0);
        exp_cnt++;
        step("stop_idle", IDLE,   0, 1, 6'd2, 0, 0);

        // Asynchronous reset in the middle of a MEM_RD wait
        step("ar_idle",   IDLE,   1, 1, 6'd35, 0, 0);
        step("ar_fetch",  FETCH,  1, 1, 6'd35, 0, 0);
        step("ar_dec",    DECODE, 1, 1, 6'd35, 0, 0);
        step("ar_addr",   MADDR,  1, 1, 6'd35, 0, 0);
        step("ar_wait",   MRD,    1, 0, 6'd35, 0, 0);
        #2;
        Reset_N = 1'b0;
        #1;
        exp_cnt = 32'd0;
        sb.push_back(ex(IDLE, 0, 0, 0));
        compare("async_reset");
        @(posedge Clk); #1;
        Reset_N = 1'b1;
        step("rel_idle",  IDLE,   1, 0, 6'd0, 0, 0);

        // Memory never ready in FETCH: TRAP after 15 cycles, sticky through Run toggles
        for (int i = 0; i < 15; i++) step("to_fetch", FETCH, 1, 0, 6'd0, 0, 0);
        exp_fault = 1'b1;
        for (int i = 0; i < 4; i++) step("trap", TRAP, logic'(i[0]), 1, 6'd0, 0, 0);

        Reset_N = 1'b0;
        #1;
        exp_fault = 1'b0;
        sb.push_back(ex(IDLE, 0, 0, 0));
        compare("trap_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Moore-style FSM that sequences the shared single-memory/single-ALU MIPS datapath over several cycles per instruction.
- Replaces the one-shot opcode decoder with per-state control strobes, including memory wait-state handshake, bus timeout and an instruction counter.
- Sits between the instruction register (opcode source) and the datapath muxes, register file, ALU and memory port.

Parameters:
- MEM_TIMEOUT, 15: max consecutive cycles a memory state waits for Mem_Ready before faulting (1..255).
- CNT_W, 32: width of Instr_Count.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_N  in  1  asynchronous active-low reset.
- Run  in  1  1 = execute; 0 = stop at next instruction boundary.
- Inst_31_26  in  6  opcode from instruction register (valid from DECODE onward).
- Mem_Ready  in  1  memory completes the current read/write this cycle.
- PC_Write  out  1  unconditional PC load.
- PC_Write_Cond  out  1  PC load if ALU Zero==0 (bne).
- PC_Source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
- IorD  out  1  memory address: 0 PC, 1 ALUOut.
- IR_Write  out  1  load instruction register.
- Mem_Read, Mem_Write  out  1 each  memory strobes.
- Mem_to_Reg  out  2  00 ALUOut, 01 MDR, 10 PC (jal link).
- Reg_Dst  out  2  00 rt, 01 rd, 10 $31.
- Reg_Write  out  1  register-file write enable.
- ALU_Src_A  out  1  0 PC, 1 rs.
- ALU_Src_B  out  2  00 rt, 01 constant 4, 10 sign-ext imm, 11 imm<<2.
- ALU_Op  out  3  000 add, 001 sub, 010 funct-decoded, 011 and, 100 or, 101 slt, 110 xor, 111 lui.
- Illegal_Op  out  1  one-cycle pulse on unsupported opcode.
- Fault  out  1  sticky memory timeout flag.
- State  out  4  current state (debug).
- Instr_Count  out  CNT_W  retired instructions.

Behaviour:
- States/encoding: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, I_EXEC 9, I_WB 10, BNE 11, JUMP 12, JAL 13, TRAP 14. Code 15 is unreachable and returns to IDLE.
- Reset (async, Reset_N=0):
  - State=IDLE, Op_Reg=0, wait counter=0, Fault=0, Instr_Count=0.
  - All strobes 0, all mux selects 0, ALU_Op=000.
- Unlisted outputs are 0 in every state.
- IDLE: all strobes 0. Go to FETCH when Run=1.
- FETCH:
  - Mem_Read=1, IorD=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Op=000, PC_Source=00.
  - IR_Write and PC_Write are asserted only in the cycle where Mem_Ready=1; state then goes to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Latch Op_Reg<=Inst_31_26. Drive ALU_Src_A=0, ALU_Src_B=11, ALU_Op=000 (branch target into ALUOut).
  - Next state by opcode: 0→R_EXEC; 35,43→MEM_ADDR; 8,10,12,13,14,15→I_EXEC; 5→BNE; 2→JUMP; 3→JAL.
  - Any other opcode: Illegal_Op=1 for this cycle, no writes, next state FETCH (or IDLE if Run=0); the instruction is not counted.
- MEM_ADDR: ALU_Src_A=1, ALU_Src_B=10, ALU_Op=000. Next MEM_RD if Op_Reg=35, else MEM_WR.
- MEM_RD: Mem_Read=1, IorD=1. Advance to MEM_WB on Mem_Ready.
- MEM_WB: Reg_Write=1, Mem_to_Reg=01, Reg_Dst=00. Retire.
- MEM_WR: Mem_Write=1, IorD=1. Retire on Mem_Ready.
- R_EXEC: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=010.
- R_WB: Reg_Write=1, Reg_Dst=01, Mem_to_Reg=00. Retire.
- I_EXEC: ALU_Src_A=1, ALU_Src_B=10, ALU_Op from Op_Reg: 8→000, 12→011, 13→100, 10→101, 14→110, 15→111.
- I_WB: Reg_Write=1, Reg_Dst=00, Mem_to_Reg=00. Retire.
- BNE: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=001, PC_Write_Cond=1, PC_Source=01. Retire. Reg_Write=0.
- JUMP: PC_Write=1, PC_Source=10. Retire.
- JAL: PC_Write=1, PC_Source=10, Reg_Write=1, Reg_Dst=10, Mem_to_Reg=10. Retire.
- Retire: Instr_Count+1 (wraps modulo 2^CNT_W). Next state FETCH if Run=1, else IDLE.
- Run=0 mid-instruction has no effect until retirement.
- Cycle counts with zero wait states: lw 5; R, I-type and sw 4; bne, j and jal 3.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle Mem_Ready=0.
  - If it reaches MEM_TIMEOUT with Mem_Ready still 0, go to TRAP. No strobes issue on that transition.
- TRAP: Fault=1 (sticky), all strobes 0. Leave only via Reset_N; Run is ignored.
- Mem_Ready outside FETCH/MEM_RD/MEM_WR is ignored.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_ADDI=8, OP_SLTI=10, OP_ANDI=12, OP_ORI=13, OP_XORI=14, OP_LUI=15, OP_BNE=5, OP_J=2, OP_JAL=3);
  - ALU_Op codes;
  - state enum;
  - mux-select encodings.
- One sub-module, mem_wait_timer: the wait counter and timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset_N=0 mid-MEM_RD → all outputs 0 and State=0 immediately, asynchronous to Clk. After release with Run=1 → FETCH next edge.
- Run=1, Mem_Ready=1 always, opcode 0 → states 1,2,7,8; R_WB shows Reg_Write=1, Reg_Dst=01; Instr_Count=1 after 4 cycles.
- Opcode 35, Mem_Ready low 3 cycles in MEM_RD → MEM_RD held 4 cycles with Mem_Read=1, IorD=1; then MEM_WB with Mem_to_Reg=01; total 8 cycles.
- Opcode 13 then 3 → I_EXEC ALU_Op=100; JAL shows PC_Write=1, Reg_Dst=10, Mem_to_Reg=10; Instr_Count=2.
- Opcode 63 → Illegal_Op pulses once in DECODE, no write strobes, back to FETCH; Instr_Count unchanged.
- MEM_TIMEOUT=15, Mem_Ready stuck 0 in FETCH → TRAP after 15 cycles, Fault=1 held while Run toggles; cleared only by Reset_N.
